// File: rtl/rx_frame_checker.sv
// ----------------------------------------------------------------------------
// rx_frame_checker
//
// Receive-side byte-stream stage between the SNI receive engine and the
// packet FIFO write port. Every accepted frame byte is forwarded with a fixed
// one-cycle latency. A reflected CRC-32 and a byte count are accumulated over
// each frame so that a per-frame status word can be issued when the frame
// ends. While the FIFO reports almost-full, a frame that has not started yet
// is dropped entirely. A frame that is already in progress is truncated: the
// current byte is written as the last byte and is flagged with out_err.
//
// Ports
//   clk, rst            RX byte clock, asynchronous active-high reset
//   in_data/in_valid    incoming frame byte (preamble/SFD already stripped)
//   in_eod              last byte of the frame, qualified by in_valid
//   fifo_afull          FIFO almost-full
//   out_data/out_valid  byte and write enable to the FIFO
//   out_eod, out_err    last written byte / frame truncated by overflow
//   stat_valid          one-cycle pulse per frame, fields hold until the next
//   stat_good .. ovf    per-frame status flags
//   stat_len            frame length including FCS, saturating at 2047
//   good_cnt, bad_cnt   saturating good / bad frame counters
// ----------------------------------------------------------------------------
module rx_frame_checker #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_eod,
   input  logic             fifo_afull,
   output logic [7:0]       out_data,
   output logic             out_valid,
   output logic             out_eod,
   output logic             out_err,
   output logic             stat_valid,
   output logic             stat_good,
   output logic             stat_crc_err,
   output logic             stat_runt,
   output logic             stat_giant,
   output logic             stat_ovf,
   output logic [10:0]      stat_len,
   output logic [CNT_W-1:0] good_cnt,
   output logic [CNT_W-1:0] bad_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      DROP  = 2'd2
   } state_t;

   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   // Register value left behind after running the CRC over a frame whose
   // FCS is correct (the FCS itself is included in the computation).
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
   localparam logic [10:0] LEN_SAT     = 11'h7FF;
   localparam logic [10:0] MIN_LEN_L   = 11'(MIN_LEN);
   localparam logic [10:0] MAX_LEN_L   = 11'(MAX_LEN);

   // One byte of the reflected CRC-32, LSB first, unrolled over 8 bits.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                              input logic [7:0]  data);
      logic [31:0] c;
      c = crc_in ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

   state_t      state;
   logic [31:0] crc;
   logic [10:0] len;

   logic        is_idle;
   logic [31:0] crc_upd;
   logic [10:0] len_base;
   logic [10:0] len_upd;
   logic        frame_ovf;
   logic        frame_crc_err;
   logic        frame_runt;
   logic        frame_giant;
   logic        frame_good;

   // Running CRC/length after including the current byte. In IDLE, the
   // current byte is the first byte of a new frame, so the accumulation
   // restarts from the initial values.
   always_comb begin
      // NOTE: every signal assigned in this block gets a value on every path,
      // so no latches are inferred.
      is_idle       = (state == IDLE);
      crc_upd       = crc32_byte(is_idle ? CRC_INIT : crc, in_data);
      len_base      = is_idle ? 11'd0 : len;
      len_upd       = (len_base == LEN_SAT) ? len_base : len_base + 11'd1;
      // A frame counts as an overflow if it has already been truncated or
      // dropped (DROP), or if it starts while the FIFO is almost full. In
      // FRAME, a last byte that coincides with almost-full is still written
      // normally, so that case does not count as an overflow.
      frame_ovf     = (state == DROP) || (is_idle && fifo_afull);
      frame_crc_err = (crc_upd != CRC_RESIDUE);
      frame_runt    = (len_upd < MIN_LEN_L);
      frame_giant   = (len_upd > MAX_LEN_L);
      frame_good    = !(frame_ovf || frame_crc_err || frame_runt || frame_giant);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         crc          <= CRC_INIT;
         len          <= 11'd0;
         out_data     <= 8'h00;
         out_valid    <= 1'b0;
         out_eod      <= 1'b0;
         out_err      <= 1'b0;
         stat_valid   <= 1'b0;
         stat_good    <= 1'b0;
         stat_crc_err <= 1'b0;
         stat_runt    <= 1'b0;
         stat_giant   <= 1'b0;
         stat_ovf     <= 1'b0;
         stat_len     <= 11'd0;
         good_cnt     <= '0;
         bad_cnt      <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only. The
         // defaults below make the write strobes single-cycle pulses.
         out_valid  <= 1'b0;
         out_eod    <= 1'b0;
         out_err    <= 1'b0;
         stat_valid <= 1'b0;

         if (in_valid) begin
            // The CRC and length keep accumulating in DROP as well, so a
            // dropped or truncated frame still reports its true length.
            crc <= crc_upd;
            len <= len_upd;

            case (state)
               IDLE: begin
                  if (fifo_afull) begin
                     // Nothing is written. A one-byte frame ends here.
                     if (!in_eod) state <= DROP;
                  end else begin
                     out_valid <= 1'b1;
                     out_data  <= in_data;
                     out_eod   <= in_eod;
                     if (!in_eod) state <= FRAME;
                  end
               end
               FRAME: begin
                  // Every byte in FRAME is written. Almost-full on a byte
                  // that is not the last one turns that byte into a
                  // truncation point.
                  out_valid <= 1'b1;
                  out_data  <= in_data;
                  if (in_eod) begin
                     out_eod <= 1'b1;
                     state   <= IDLE;
                  end else if (fifo_afull) begin
                     out_eod <= 1'b1;
                     out_err <= 1'b1;
                     state   <= DROP;
                  end
               end
               DROP: begin
                  if (in_eod) state <= IDLE;
               end
               default: state <= IDLE;
            endcase

            if (in_eod) begin
               stat_valid   <= 1'b1;
               stat_good    <= frame_good;
               stat_crc_err <= frame_crc_err;
               stat_runt    <= frame_runt;
               stat_giant   <= frame_giant;
               stat_ovf     <= frame_ovf;
               stat_len     <= len_upd;
               if (frame_good) begin
                  if (good_cnt != {CNT_W{1'b1}}) good_cnt <= good_cnt + CNT_W'(1);
               end else begin
                  if (bad_cnt != {CNT_W{1'b1}}) bad_cnt <= bad_cnt + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: doc/rx_frame_checker.md
Name: rx_frame_checker

Overview:
- Byte-stream stage in the RX clock domain, between the SNI receive engine and the packet FIFO write port.
- Forwards each received frame byte to the FIFO with a fixed 1-cycle latency.
- Computes CRC-32 over every frame and checks the frame length; reports per-frame status and keeps saturating good/bad frame counters.
- Drops or truncates a frame when the FIFO signals almost-full.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes (DA through FCS).
- MAX_LEN, 1518, maximum legal frame length in bytes.
- CNT_W, 16, width of the good/bad frame counters.

Ports:
- clk  in  1  RX byte clock (receive clock / 8 domain, same clock as the FIFO write side).
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  frame byte; preamble/SFD already stripped.
- in_valid  in  1  in_data valid this cycle.
- in_eod  in  1  last byte of frame; qualified by in_valid.
- fifo_afull  in  1  FIFO almost-full.
- out_data  out  8  byte to FIFO di.
- out_valid  out  1  FIFO we.
- out_eod  out  1  FIFO EOD_in; marks the last written byte.
- out_err  out  1  with out_eod: frame was truncated by overflow.
- stat_valid  out  1  1-cycle pulse at end of every frame, including dropped frames.
- stat_good  out  1  CRC ok, length in range, no overflow.
- stat_crc_err  out  1  CRC residue mismatch.
- stat_runt  out  1  length < MIN_LEN.
- stat_giant  out  1  length > MAX_LEN.
- stat_ovf  out  1  frame dropped or truncated.
- stat_len  out  11  byte count including FCS, saturates at 2047.
- good_cnt  out  CNT_W  saturating count of good frames.
- bad_cnt  out  CNT_W  saturating count of all other frames.

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, crc=32'hFFFFFFFF, length=0, counters 0.
- All outputs are registered. Output for input cycle N appears in cycle N+1.
- CRC: reflected CRC-32, polynomial 32'hEDB88320, init 32'hFFFFFFFF, byte processed bit 0 first over all bytes including FCS.
  - Frame CRC is good iff the post-update register on the last byte equals 32'hDEBB20E3.
  - The next-CRC function is combinational and byte-wide (8 unrolled steps).
- Length counter: increments per accepted in_valid byte, saturates at 2047.
- State machine:
  - IDLE:
    - in_valid & ~fifo_afull: forward byte, load crc/len with the first byte, go to FRAME.
    - in_valid & fifo_afull: forward nothing, go to DROP with ovf latched.
    - A byte with in_valid & in_eod in IDLE is a 1-byte frame: forwarded with out_eod, status issued, stay IDLE.
  - FRAME:
    - in_valid & ~fifo_afull: forward byte, update crc/len.
    - in_valid & fifo_afull & ~in_eod: forward this byte with out_eod=1 and out_err=1, latch ovf, go to DROP.
    - in_valid & in_eod: forward with out_eod=1; issue status next to it; go to IDLE.
    - in_valid low: hold state, no output.
  - DROP:
    - Consume bytes without forwarding; crc/len keep updating.
    - On in_eod: issue status with stat_ovf=1, stat_good=0; go to IDLE.
    - out_valid stays 0 throughout DROP.
- Status: stat_valid and all stat_* fields are asserted in the same cycle as out_eod, or one cycle after in_eod for dropped frames.
  - Fields hold their values until the next stat_valid.
  - Every frame produces exactly one stat_valid.
  - good_cnt increments on stat_good; bad_cnt increments otherwise. Neither wraps.
- Simultaneous fifo_afull and in_eod in FRAME: the byte is forwarded normally; no truncation.
- Reset mid-frame: frame abandoned, no out_eod, no status, counters cleared.

Test Plan:
- 64-byte frame with correct FCS, in_valid continuous:
  - out_valid for 64 cycles, starting 1 cycle after first input.
  - out_eod on byte 64.
  - stat_good=1, stat_len=64, good_cnt=1.
- Same frame with bit 0 of byte 20 flipped:
  - all 64 bytes forwarded.
  - stat_crc_err=1, stat_good=0, bad_cnt=1.
- 60-byte frame with valid FCS -> stat_runt=1, stat_len=60. 1519-byte frame -> stat_giant=1, stat_len=1519.
- fifo_afull high at first byte of a 100-byte frame -> no out_valid; stat_valid one cycle after in_eod with stat_ovf=1, stat_len=100.
- fifo_afull raised at byte 30 of a 100-byte frame:
  - bytes 1-30 forwarded; byte 30 carries out_eod=1, out_err=1.
  - no further out_valid; stat_ovf=1 after in_eod.
- rst pulsed at byte 40, then a good 64-byte frame -> no out_eod for the aborted frame; good_cnt=1, bad_cnt=0; with in_valid gaps, output matches input order.
